div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Sequences the shared 64-bit iterative unsigned divider core for RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW.
//  Sits between the Ex stage and the divider core.
//  Accepts one request at a time over a valid/ready handshake and converts signed operands to magnitudes.
//  Resolves divide-by-zero and signed overflow without launching the core, launches the core otherwise, then applies sign and word-width fix-up and returns the result under valid/ready.
// PARAMETERS
//  XLEN        64  datapath width; only 64 is supported
//  ADDR_W      5   destination register address width
// PORTS
//  Clk          in   1       clock, rising edge
//  Rst          in   1       synchronous reset, active-low
//  ReqValid     in   1       Ex presents a divide request
//  ReqReady     out  1       sequencer can accept (state IDLE)
//  ReqFunct3    in   3       100 DIV, 101 DIVU, 110 REM, 111 REMU
//  ReqIsWord    in   1       1 = *W variant (32-bit operands)
//  ReqRs1       in   XLEN    dividend
//  ReqRs2       in   XLEN    divisor
//  ReqRdAddr    in   ADDR_W  destination register
//  Flush        in   1       pipeline flush; kill the in-flight op
//  CoreHoldFlag out  2       2'b10 for exactly one cycle = core start, else 2'b00
//  CoreDividend out  XLEN    unsigned dividend magnitude, stable from start pulse to CoreDone
//  CoreDivisor  out  XLEN    unsigned divisor magnitude, stable from start pulse to CoreDone
//  CoreQuotient in   XLEN    core quotient, valid while CoreDone
//  CoreRemainder in  XLEN    core remainder, valid while CoreDone
//  CoreDone     in   1       one-cycle end pulse from core
//  RespValid    out  1       result available
//  RespReady    in   1       Ex/WB accepts result
//  RespData     out  XLEN    final result (sign-extended for *W)
//  RespRdAddr   out  ADDR_W  destination register of result
//  Busy         out  1       ~ReqReady; feeds pipeline stall control
// BEHAVIOUR
//  Reset (Rst=0 at posedge):
//   - state IDLE; ReqReady=1, Busy=0.
//   - RespValid=0, RespData=0, RespRdAddr=0, CoreHoldFlag=00; Kill flag cleared; operand registers 0.
//   - Reset mid-operation aborts everything; a CoreDone arriving later is ignored in IDLE.
//  FSM: IDLE -> LAUNCH -> WAIT -> FIX -> RESP -> IDLE; special cases take IDLE -> RESP directly.
//  IDLE, on ReqValid&ReqReady:
//   - Register funct3, IsWord, RdAddr and operands. For *W, operands are low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops).
//   - Divisor==0: go to RESP next cycle. Q=all ones; R=dividend (*W: sign-extended low 32).
//   - Signed, dividend==most-negative (2^63, or 2^31 for *W) and divisor==-1: go to RESP. Q=dividend (sign-extended); R=0.
//   - Otherwise register |dividend| and |divisor| plus negQ=sa^sb and negR=sa (signed ops only), then go to LAUNCH.
//  LAUNCH: CoreHoldFlag=2'b10 for this one cycle, then WAIT.
//  WAIT: hold core operands until CoreDone=1, then capture CoreQuotient/CoreRemainder and go to FIX.
//  FIX (1 cycle):
//   - Q' = negQ ? -Q : Q; R' = negR ? -R : R.
//   - Select Q' for DIV*, R' for REM*. For *W, RespData = {{32{res[31]}}, res[31:0]}. Go to RESP.
//  RESP:
//   - RespValid=1; RespData and RespRdAddr stay stable until RespValid&RespReady.
//   - Then go to IDLE; ReqReady=1 in the following cycle (no same-cycle re-accept).
//  Latency: special case = 1 cycle accept->RespValid; normal = 2 + core latency + 1 cycles.
//  Flush:
//   - IDLE: no effect; a request presented with Flush=1 is not accepted.
//   - LAUNCH or WAIT: set Kill. The core cannot be aborted, so stay in WAIT until CoreDone, discard the result, then go to IDLE with RespValid never asserted.
//   - FIX or RESP: drop the result and go to IDLE next cycle.
//  CoreDone outside WAIT is ignored. Only one op is in flight; no queuing.
// TESTING
//  1 DIV rs1=-7, rs2=2 -> CoreDividend=7, CoreDivisor=2; RespData=0xFFFF_FFFF_FFFF_FFFD (-3). REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
//  2 DIVU rs1=5, rs2=0 -> CoreHoldFlag never 10; RespValid 1 cycle after accept; RespData=all ones. REMU same -> 5.
//  3 DIVW rs1=0x8000_0000, rs2=-1 -> no core launch; RespData=0xFFFF_FFFF_8000_0000. REMW same -> 0.
//  4 DIVUW rs1=0xFFFF_FFFF_0000_000A, rs2=3 -> CoreDividend=0xA; RespData=3.
//  5 Flush 2 cycles after LAUNCH -> RespValid stays 0; ReqReady returns 1 only after CoreDone; next request completes correctly.
//  6 RespReady=0 for 5 cycles in RESP -> RespValid and RespData held stable, no new accept; Rst=0 mid-WAIT -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/div_sequencer.sv
// Front-end sequencer for the shared iterative 64-bit divider: operand prep,
// special-case resolution, core launch/wait, sign and word fix-up, result handshake.
module div_sequencer #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [2:0]        ReqFunct3,
  input  logic              ReqIsWord,
  input  logic [XLEN-1:0]   ReqRs1,
  input  logic [XLEN-1:0]   ReqRs2,
  input  logic [ADDR_W-1:0] ReqRdAddr,
  input  logic              Flush,
  output logic [1:0]        CoreHoldFlag,
  output logic [XLEN-1:0]   CoreDividend,
  output logic [XLEN-1:0]   CoreDivisor,
  input  logic [XLEN-1:0]   CoreQuotient,
  input  logic [XLEN-1:0]   CoreRemainder,
  input  logic              CoreDone,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [XLEN-1:0]   RespData,
  output logic [ADDR_W-1:0] RespRdAddr,
  output logic              Busy
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIX, S_RESP} state_t;

  state_t state_q, state_d;

  logic              is_rem_q, is_rem_d;
  logic              is_word_q, is_word_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   core_quo_q, core_quo_d;
  logic [XLEN-1:0]   core_rem_q, core_rem_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;

  // funct3[2] is set for every divide-group encoding, so only [1:0] steer the op.
  logic unused_funct3;
  assign unused_funct3 = ReqFunct3[2];

  function automatic logic [XLEN-1:0] word_fix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  logic            req_signed, req_rem, accept, special;
  logic            div_zero, overflow, sa, sb;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, special_res;
  logic [XLEN-1:0] q_fix, r_fix;

  always_comb begin
    req_signed = ~ReqFunct3[0];
    req_rem    = ReqFunct3[1];
    a_ext = ReqIsWord ? {{(XLEN-32){req_signed & ReqRs1[31]}}, ReqRs1[31:0]} : ReqRs1;
    b_ext = ReqIsWord ? {{(XLEN-32){req_signed & ReqRs2[31]}}, ReqRs2[31:0]} : ReqRs2;
    min_val = ReqIsWord ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    overflow = req_signed && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero | overflow;
    sa = req_signed & a_ext[XLEN-1];
    sb = req_signed & b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;
    // Divide-by-zero wins over overflow: its divisor can never be -1.
    if (div_zero) special_res = req_rem ? a_ext : '1;
    else          special_res = req_rem ? '0 : a_ext;
    special_res = word_fix(ReqIsWord, special_res);
    accept = (state_q == S_IDLE) && ReqValid && !Flush;
    q_fix = neg_q_q ? -core_quo_q : core_quo_q;
    r_fix = neg_r_q ? -core_rem_q : core_rem_q;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = special ? S_RESP : S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      // A killed op still has to drain the core before the next launch.
      S_WAIT:   if (CoreDone) state_d = (kill_q || Flush) ? S_IDLE : S_FIX;
      S_FIX:    state_d = Flush ? S_IDLE : S_RESP;
      S_RESP:   if (Flush || RespReady) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ReqReady     = (state_q == S_IDLE);
    Busy         = (state_q != S_IDLE);
    CoreHoldFlag = (state_q == S_LAUNCH) ? 2'b10 : 2'b00;
    RespValid    = (state_q == S_RESP);
    CoreDividend = dvd_q;
    CoreDivisor  = dvs_q;
    RespData     = resp_data_q;
    RespRdAddr   = rd_addr_q;
  end

  always_comb begin
    is_rem_d    = is_rem_q;
    is_word_d   = is_word_q;
    rd_addr_d   = rd_addr_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    kill_d      = kill_q;
    core_quo_d  = core_quo_q;
    core_rem_d  = core_rem_q;
    resp_data_d = resp_data_q;
    if (accept) begin
      is_rem_d  = req_rem;
      is_word_d = ReqIsWord;
      rd_addr_d = ReqRdAddr;
      dvd_d     = a_mag;
      dvs_d     = b_mag;
      neg_q_d   = sa ^ sb;
      neg_r_d   = sa;
      if (special) resp_data_d = special_res;
    end
    if ((state_q == S_LAUNCH || state_q == S_WAIT) && Flush) kill_d = 1'b1;
    if (state_q == S_WAIT && CoreDone) begin
      core_quo_d = CoreQuotient;
      core_rem_d = CoreRemainder;
      kill_d     = 1'b0;
    end
    if (state_q == S_FIX) resp_data_d = word_fix(is_word_q, is_rem_q ? r_fix : q_fix);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      is_rem_q    <= 1'b0;
      is_word_q   <= 1'b0;
      rd_addr_q   <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      kill_q      <= 1'b0;
      core_quo_q  <= '0;
      core_rem_q  <= '0;
      resp_data_q <= '0;
    end else begin
      is_rem_q    <= is_rem_d;
      is_word_q   <= is_word_d;
      rd_addr_q   <= rd_addr_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      kill_q      <= kill_d;
      core_quo_q  <= core_quo_d;
      core_rem_q  <= core_rem_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed + randomized check of div_sequencer against an RV64M result model
// and a behavioural divider core with variable latency.
module tb_div_sequencer;

  logic        Clk, Rst;
  logic        ReqValid, ReqReady, ReqIsWord, Flush;
  logic [2:0]  ReqFunct3;
  logic [63:0] ReqRs1, ReqRs2;
  logic [4:0]  ReqRdAddr, RespRdAddr;
  logic [1:0]  CoreHoldFlag;
  logic [63:0] CoreDividend, CoreDivisor, CoreQuotient, CoreRemainder, RespData;
  logic        CoreDone, RespValid, RespReady, Busy;

  div_sequencer #(.XLEN(64), .ADDR_W(5)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqFunct3(ReqFunct3), .ReqIsWord(ReqIsWord),
    .ReqRs1(ReqRs1), .ReqRs2(ReqRs2), .ReqRdAddr(ReqRdAddr), .Flush(Flush),
    .CoreHoldFlag(CoreHoldFlag), .CoreDividend(CoreDividend), .CoreDivisor(CoreDivisor),
    .CoreQuotient(CoreQuotient), .CoreRemainder(CoreRemainder), .CoreDone(CoreDone),
    .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
    .RespRdAddr(RespRdAddr), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, done_cyc = 0;
  int n_starts = 0, force_lat = 0, last_lat = 0, bad_flag = 0, stab_err = 0;
  logic [63:0] last_dvd = '0, last_dvs = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Divider core: watches for the start pulse, returns dvd/dvs after a latency.
  initial begin
    logic [63:0] dvd, dvs;
    int lat;
    CoreDone = 1'b0; CoreQuotient = '0; CoreRemainder = '0;
    forever begin
      @(negedge Clk);
      if (CoreHoldFlag == 2'b10) begin
        n_starts++;
        dvd = CoreDividend; dvs = CoreDivisor;
        last_dvd = dvd; last_dvs = dvs;
        lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 5));
        last_lat = lat;
        for (int k = 0; k < lat; k++) begin
          @(negedge Clk);
          if (CoreHoldFlag != 2'b00) bad_flag++;
          if (Rst && Busy && (CoreDividend !== dvd || CoreDivisor !== dvs)) stab_err++;
        end
        CoreQuotient  = (dvs != 0) ? dvd / dvs : '1;
        CoreRemainder = (dvs != 0) ? dvd % dvs : dvd;
        CoreDone = 1'b1;
        done_cyc = cyc;
        @(negedge Clk);
        CoreDone = 1'b0;
        CoreQuotient  = {$urandom, $urandom};
        CoreRemainder = {$urandom, $urandom};
      end else if (CoreHoldFlag != 2'b00) bad_flag++;
    end
  end

  // RV64M architectural result, written with native signed/unsigned arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    int sa, sb; int unsigned ua, ub; logic [31:0] r32;
    longint la, lb; longint unsigned lua, lub; logic [63:0] r;
    sa = int'(a[31:0]); sb = int'(b[31:0]); ua = a[31:0]; ub = b[31:0];
    la = longint'(a); lb = longint'(b); lua = a; lub = b;
    r32 = '0; r = '0;
    if (w) begin
      case (f3[1:0])
        2'b00: if (sb == 0) r32 = '1; else if (sa == 32'sh8000_0000 && sb == -1) r32 = sa; else r32 = sa / sb;
        2'b01: r32 = (ub == 0) ? '1 : ua / ub;
        2'b10: if (sb == 0) r32 = sa; else if (sa == 32'sh8000_0000 && sb == -1) r32 = 0; else r32 = sa % sb;
        default: r32 = (ub == 0) ? ua : ua % ub;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (f3[1:0])
        2'b00: if (lb == 0) r = '1; else if (la == 64'sh8000_0000_0000_0000 && lb == -1) r = la; else r = la / lb;
        2'b01: r = (lub == 0) ? '1 : lua / lub;
        2'b10: if (lb == 0) r = la; else if (la == 64'sh8000_0000_0000_0000 && lb == -1) r = 0; else r = la % lb;
        default: r = (lub == 0) ? lua : lua % lub;
      endcase
    end
    return r;
  endfunction

  function automatic logic [63:0] ext_op(input logic [2:0] f3, input logic w, input logic [63:0] v);
    if (!w) return v;
    return f3[0] ? {32'h0, v[31:0]} : {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] mag(input logic [2:0] f3, input logic w, input logic [63:0] v);
    logic [63:0] e;
    e = ext_op(f3, w, v);
    return (!f3[0] && e[63]) ? -e : e;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea, eb, mn;
    ea = ext_op(f3, w, a); eb = ext_op(f3, w, b);
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    return (eb == 0) || (!f3[0] && ea == mn && eb == '1);
  endfunction

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ReqReady && k < 100) begin @(negedge Clk); k++; end
    chk(tag, 64'(ReqReady), 64'd1);
  endtask

  task automatic present(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
    ReqValid = 1'b1; ReqFunct3 = f3; ReqIsWord = w; ReqRs1 = a; ReqRs2 = b; ReqRdAddr = rd;
    @(negedge Clk);
    ReqValid = 1'b0; ReqRs1 = {$urandom, $urandom}; ReqRs2 = {$urandom, $urandom};
    ReqRdAddr = 5'($urandom); ReqIsWord = 1'($urandom);
  endtask

  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input int hold);
    logic [63:0] exp_d;
    int s0, k;
    bit sp;
    exp_d = ref_res(f3, w, a, b);
    sp = is_special(f3, w, a, b);
    wait_ready("req_ready");
    s0 = n_starts;
    present(f3, w, a, b, rd);
    k = 1;
    while (!RespValid && k < 200) begin @(negedge Clk); k++; end
    chk("resp_valid", 64'(RespValid), 64'd1);
    chk("resp_data", RespData, exp_d);
    chk("resp_rd", 64'(RespRdAddr), 64'(rd));
    if (sp) begin
      chk("lat_special", 64'(k), 64'd1);
      chk("no_launch", 64'(n_starts - s0), 64'd0);
    end else begin
      chk("lat_normal", 64'(k), 64'(3 + last_lat));
      chk("one_launch", 64'(n_starts - s0), 64'd1);
      chk("core_dvd", last_dvd, mag(f3, w, a));
      chk("core_dvs", last_dvs, mag(f3, w, b));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk("hold_data", RespData, exp_d);
      chk("hold_vrb", 64'({RespValid, ReqReady, Busy}), 64'b101);
    end
    RespReady = 1'b1;
    @(negedge Clk);
    RespReady = 1'b0;
    chk("post_idle", 64'({RespValid, ReqReady, Busy}), 64'b010);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom, 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    bit saw;
    int s0;
    Rst = 1'b0; ReqValid = 1'b0; ReqFunct3 = 3'b100; ReqIsWord = 1'b0;
    ReqRs1 = '0; ReqRs2 = '0; ReqRdAddr = '0; Flush = 1'b0; RespReady = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_rdy_busy", 64'({ReqReady, Busy, RespValid}), 64'b100);
    chk("rst_flag", 64'(CoreHoldFlag), 64'd0);
    chk("rst_data", RespData, 64'd0);
    chk("rst_rd", 64'(RespRdAddr), 64'd0);
    chk("rst_ops", CoreDividend | CoreDivisor, 64'd0);
    Rst = 1'b1;
    @(negedge Clk);

    do_op(3'b100, 1'b0, -64'd7, 64'd2, 5'd3, 0);
    do_op(3'b110, 1'b0, -64'd7, 64'd2, 5'd4, 0);
    do_op(3'b101, 1'b0, 64'd5, 64'd0, 5'd5, 0);
    do_op(3'b111, 1'b0, 64'd5, 64'd0, 5'd6, 0);
    do_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd7, 0);
    do_op(3'b110, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd8, 0);
    do_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd9, 0);
    do_op(3'b101, 1'b1, 64'hFFFF_FFFF_0000_000A, 64'd3, 5'd10, 0);
    do_op(3'b110, 1'b0, 64'd100, -64'd7, 5'd11, 5);

    // Request with Flush in IDLE must not be taken.
    s0 = n_starts;
    ReqValid = 1'b1; Flush = 1'b1; ReqFunct3 = 3'b101; ReqIsWord = 1'b0;
    ReqRs1 = 64'd9; ReqRs2 = 64'd0;
    @(negedge Clk);
    ReqValid = 1'b0; Flush = 1'b0;
    @(negedge Clk);
    chk("idle_flush", 64'({RespValid, ReqReady, Busy}), 64'b010);
    chk("idle_flush_nolaunch", 64'(n_starts - s0), 64'd0);

    // Flush two cycles after LAUNCH: result discarded once the core drains.
    force_lat = 8;
    wait_ready("req_ready_fl");
    present(3'b100, 1'b0, 64'd100, 64'd7, 5'd12);
    @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 50 && !ReqReady; i++) begin
      @(negedge Clk);
      if (RespValid) saw = 1'b1;
    end
    chk("flush_no_resp", 64'(saw), 64'd0);
    chk("flush_ready_after_done", 64'(cyc), 64'(done_cyc + 1));
    force_lat = 0;
    do_op(3'b111, 1'b0, 64'd100, 64'd7, 5'd13, 1);

    // Flush while the result is waiting in RESP.
    wait_ready("req_ready_fr");
    present(3'b101, 1'b0, 64'd42, 64'd0, 5'd14);
    chk("resp_before_flush", 64'(RespValid), 64'd1);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    chk("resp_flush", 64'({RespValid, ReqReady}), 64'b01);

    // Reset in WAIT; the late CoreDone must be ignored.
    force_lat = 10;
    wait_ready("req_ready_rs");
    present(3'b100, 1'b0, -64'd50, 64'd3, 5'd15);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    chk("mid_rst_ctl", 64'({ReqReady, Busy, RespValid, CoreHoldFlag}), 64'b10000);
    chk("mid_rst_ops", CoreDividend | CoreDivisor, 64'd0);
    chk("mid_rst_resp", 64'({RespData, RespRdAddr}), 64'd0);
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      if (RespValid || !ReqReady) saw = 1'b1;
    end
    chk("late_done_ignored", 64'(saw), 64'd0);
    force_lat = 0;

    for (int i = 0; i < 40; i++)
      do_op(3'(4 + $urandom_range(0, 3)), 1'($urandom), pick(), pick(),
            5'($urandom), int'($urandom_range(0, 2)));

    chk("core_flag_shape", 64'(bad_flag), 64'd0);
    chk("core_ops_stable", 64'(stab_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
